gf180mcu_fd_sc_mcu9t5v0__and4_bist: RTL and testbench
=====================================================

# gf180mcu_fd_sc_mcu9t5v0__and4_bist

Built-in self-test driver/checker for the 4-input AND cell family. It sits on the input side of a device under test (DUT): it drives A1..A4 through all 16 input patterns, samples the DUT's Z output, and compares it with the expected AND of the four inputs. It reports pass/fail, an error count and the first failing pattern. It is used in library test structures and silicon characterization tiles next to `and4_1/2/4` instances.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each pattern is held before Z is checked. Legal range 1..15; the counter is 4 bits.

Ports:
- `CLK`, input, 1: rising-edge clock.
- `RN`, input, 1: reset. Asynchronous, active-low. Clears all state immediately.
- `START`, input, 1: start request, sampled in IDLE and DONE only.
- `A1`, `A2`, `A3`, `A4`, output, 1 each: registered stimulus to the DUT. A1 is the pattern LSB, A4 the MSB.
- `Z`, input, 1: DUT output, compared synchronously.
- `BUSY`, output, 1: high while a sweep is in progress.
- `DONE`, output, 1: high from sweep completion until the next start or reset.
- `PASS`, output, 1: valid when DONE is high. 1 when ERRCNT == 0.
- `ERRCNT`, output, 5: count of mismatching patterns, 0..16.
- `FIRST_FAIL`, output, 4: first pattern that mismatched. Holds 0 if there were no errors.
- `VDD`, `VSS`, inout, 1 each: present only under `USE_POWER_PINS`.

## Operation
- State machine: IDLE, DRIVE, DONE_ST.
- IDLE:
  - A1..A4 = 0, BUSY = 0, DONE = 0.
  - START = 1 → DRIVE. Load pat = 0, cnt = SETTLE-1, ERRCNT = 0, FIRST_FAIL = 0, and clear the internal flag `seen`.
- DRIVE:
  - {A4,A3,A2,A1} = pat and BUSY = 1.
  - Each edge with cnt != 0: decrement cnt.
  - Edge with cnt == 0 (the check edge):
    - Compare Z with &pat.
    - On mismatch: ERRCNT += 1. If `seen` == 0, FIRST_FAIL = pat and set `seen`.
    - If pat == 15 → DONE_ST. Otherwise pat += 1 and cnt = SETTLE-1.
  - START is ignored in DRIVE.
- DONE_ST:
  - DONE = 1, BUSY = 0. A1..A4 hold 4'hF, the last pattern driven.
  - PASS = (ERRCNT == 0).
  - START = 1 → DRIVE, with the same clears as from IDLE.
- ERRCNT cannot exceed 16 and needs no saturation. pat does not wrap; it stops at 15.
- Z = X/Z on the check edge counts as a mismatch in simulation, per the `!==` comparison.
- Reset at any time, including mid-sweep:
  - State returns to IDLE; all outputs go to 0.
  - PASS = 0, because DONE = 0.

## Timing
- All outputs are registered. No combinational path from Z or START to any output.
- A START edge at t0 produces pattern 0 on A after t0. The check edge for pattern k is t0 + (k+1)·SETTLE.
- DONE rises after edge t0 + 16·SETTLE. ERRCNT, PASS and FIRST_FAIL are final in the same cycle.
- BUSY is high for exactly 16·SETTLE cycles.
- A START held high continuously restarts a sweep one cycle after each completion. DONE is then visible for one cycle.
- Reset values: A1..A4 = 0, BUSY = 0, DONE = 0, PASS = 0, ERRCNT = 0, FIRST_FAIL = 0.

## Structure
- Shared package/include `gf180mcu_fd_sc_mcu9t5v0__bist_defs`:
  - State encodings S_IDLE = 2'd0, S_DRIVE = 2'd1, S_DONE = 2'd2.
  - PAT_W = 4, ERR_W = 5.
  - Maximum SETTLE = 15.
- One sub-module, `gf180mcu_fd_sc_mcu9t5v0__bist_settle_ctr`:
  - 4-bit down counter with load value, load, enable and a `zero` flag.
  - Also reused by the planned and2/and3/or4 BIST variants.
- Top level holds the FSM, the pattern register, the compare logic and the result registers.
- Power-pin port lists and `FUNCTIONAL` guards match the library cell wrappers.

## Test plan
- SETTLE = 2, Z driven by a behavioural and4_1 model from A1..A4; START pulsed for 1 cycle → BUSY for 32 cycles, then DONE = 1, PASS = 1, ERRCNT = 0, FIRST_FAIL = 0.
- Z stuck-at-0 → DONE with ERRCNT = 1, FIRST_FAIL = 4'hF, PASS = 0.
- Z stuck-at-1 → ERRCNT = 15, FIRST_FAIL = 4'h0, PASS = 0.
- Z = OR4 of the inputs, SETTLE = 1 → 16-cycle sweep, ERRCNT = 14, FIRST_FAIL = 4'h1.
- RN pulsed low at cycle 10 of a SETTLE = 2 sweep → all outputs 0 immediately. A new START gives a full clean 32-cycle sweep.
- START pulsed at cycle 5 of a sweep → ignored; DONE still at cycle 32. START in DONE_ST → ERRCNT and FIRST_FAIL cleared and a new sweep runs.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_defs.sv
// Shared definitions for the gf180mcu 9t cell-family BIST drivers/checkers.
// State encodings, widths and settle limits common to the and/or BIST variants.
package gf180mcu_fd_sc_mcu9t5v0__bist_defs;

    localparam int unsigned PAT_W      = 4;
    localparam int unsigned ERR_W      = 5;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SETTLE_MAX = 15;

    localparam logic [PAT_W-1:0] PAT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Golden response of a 4-input AND cell for a given stimulus pattern.
    function automatic logic and4_expect(input logic [PAT_W-1:0] pat);
        return &pat;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_settle_ctr.sv
// Loadable 4-bit down counter used to hold each BIST pattern for SETTLE cycles.
// Counts down while enabled and parks at zero; load takes priority over enable.
module gf180mcu_fd_sc_mcu9t5v0__bist_settle_ctr
    import gf180mcu_fd_sc_mcu9t5v0__bist_defs::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__and4_bist.sv
// BIST driver/checker for the and4 cell: sweeps all 16 input patterns on A1..A4,
// compares Z against the AND of the pattern and reports pass, error count and first failure.
module gf180mcu_fd_sc_mcu9t5v0__and4_bist
    import gf180mcu_fd_sc_mcu9t5v0__bist_defs::*;
#(
    parameter int unsigned SETTLE = 2
)(
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             A4,
    input  logic             Z,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERRCNT,
    output logic [PAT_W-1:0] FIRST_FAIL
);

    if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_settle_range
        $error("SETTLE must be in 1..15");
    end

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    state_t           state;
    logic [PAT_W-1:0] pat;
    logic             seen;

    logic             start_go;
    logic             check;
    logic             mismatch;
    logic             last;
    logic             ctr_load;
    logic             ctr_en;
    logic             ctr_zero;
    logic [CNT_W-1:0] ctr_count;
    logic [ERR_W-1:0] err_next;

    gf180mcu_fd_sc_mcu9t5v0__bist_settle_ctr u_settle (
        .clk      (CLK),
        .rst_n    (RN),
        .load     (ctr_load),
        .load_val (LOAD_VAL),
        .en       (ctr_en),
        .count    (ctr_count),
        .zero     (ctr_zero)
    );

    // Case inequality so an X/Z on Z is scored as a mismatch in simulation.
    always_comb begin
        start_go = START && ((state == S_IDLE) || (state == S_DONE));
        check    = (state == S_DRIVE) && ctr_zero;
        mismatch = (Z !== and4_expect(pat));
        last     = (pat == PAT_LAST);
        ctr_load = start_go || (check && !last);
        ctr_en   = (state == S_DRIVE);
        err_next = ERRCNT + ERR_W'(mismatch);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state      <= S_IDLE;
            pat        <= '0;
            seen       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERRCNT     <= '0;
            FIRST_FAIL <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_go) begin
                        state      <= S_DRIVE;
                        pat        <= '0;
                        seen       <= 1'b0;
                        BUSY       <= 1'b1;
                        DONE       <= 1'b0;
                        PASS       <= 1'b0;
                        ERRCNT     <= '0;
                        FIRST_FAIL <= '0;
                    end
                end
                S_DRIVE: begin
                    if (check) begin
                        if (mismatch) begin
                            ERRCNT <= err_next;
                            if (!seen) begin
                                FIRST_FAIL <= pat;
                                seen       <= 1'b1;
                            end
                        end
                        if (last) begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (err_next == '0);
                        end else begin
                            pat <= pat + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // pat is only ever 0 in IDLE and parks at 4'hF in DONE, so it doubles as the stimulus register.
    assign {A4, A3, A2, A1} = pat;

    logic unused_ok;
    assign unused_ok = ^ctr_count;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__and4_bist.sv
// Self-checking bench for the and4 BIST: table-driven sweeps with a result scoreboard,
// plus hand sequences for mid-sweep reset and back-to-back restarts.
module tb_gf180mcu_fd_sc_mcu9t5v0__and4_bist;

    typedef struct {
        int         sel;       // 0: SETTLE=2 instance, 1: SETTLE=1 instance
        int         zmode;     // 0 and4, 1 stuck0, 2 stuck1, 3 or4, 4 buf A1, 5 nand4
        int         poke;      // sweep cycle at which a stray START is pulsed (-1: none)
        int         exp_err;
        logic [3:0] exp_ff;
        logic       exp_pass;
        int         exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    logic start2 = 1'b0, start1 = 1'b0;
    int   zm2 = 0, zm1 = 0;
    int   sel = 0;

    logic       a1_2, a2_2, a3_2, a4_2, z2, busy2, done2, pass2;
    logic [4:0] err2;
    logic [3:0] ff2;
    logic       a1_1, a2_1, a3_1, a4_1, z1, busy1, done1, pass1;
    logic [4:0] err1;
    logic [3:0] ff1;

    logic [3:0] cur_a;
    logic       cur_busy, cur_done, cur_pass;
    logic [4:0] cur_err;
    logic [3:0] cur_ff;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[8];
    vec_t sb[$];

    always #5 clk = ~clk;

    function automatic logic zfun(input int mode, input logic [3:0] a);
        case (mode)
            0:       return &a;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return |a;
            4:       return a[0];
            default: return ~&a;
        endcase
    endfunction

    always_comb z2 = zfun(zm2, {a4_2, a3_2, a2_2, a1_2});
    always_comb z1 = zfun(zm1, {a4_1, a3_1, a2_1, a1_1});

    always_comb begin
        if (sel == 0) begin
            cur_a = {a4_2, a3_2, a2_2, a1_2}; cur_busy = busy2; cur_done = done2;
            cur_pass = pass2; cur_err = err2; cur_ff = ff2;
        end else begin
            cur_a = {a4_1, a3_1, a2_1, a1_1}; cur_busy = busy1; cur_done = done1;
            cur_pass = pass1; cur_err = err1; cur_ff = ff1;
        end
    end

    gf180mcu_fd_sc_mcu9t5v0__and4_bist #(.SETTLE(2)) u_dut2 (
        .CLK(clk), .RN(rn), .START(start2),
        .A1(a1_2), .A2(a2_2), .A3(a3_2), .A4(a4_2), .Z(z2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERRCNT(err2), .FIRST_FAIL(ff2)
    );

    gf180mcu_fd_sc_mcu9t5v0__and4_bist #(.SETTLE(1)) u_dut1 (
        .CLK(clk), .RN(rn), .START(start1),
        .A1(a1_1), .A2(a2_1), .A3(a3_1), .A4(a4_1), .Z(z1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERRCNT(err1), .FIRST_FAIL(ff1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start2 = v; else start1 = v;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a2"},    {a4_2, a3_2, a2_2, a1_2}, 0);
        chk({tag, "_busy2"}, busy2, 0);
        chk({tag, "_done2"}, done2, 0);
        chk({tag, "_pass2"}, pass2, 0);
        chk({tag, "_err2"},  err2, 0);
        chk({tag, "_ff2"},   ff2, 0);
        chk({tag, "_a1"},    {a4_1, a3_1, a2_1, a1_1}, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_done1"}, done1, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   nbusy;
        int   cyc;
        vec_t e;
        string t;
        t = $sformatf("v%0d", idx);
        sel = v.sel;
        if (v.sel == 0) zm2 = v.zmode; else zm1 = v.zmode;
        sb.push_back(v);
        @(negedge clk);
        set_start(v.sel, 1'b1);
        @(negedge clk);
        set_start(v.sel, 1'b0);
        chk({t, "_clr_err"},  cur_err, 0);
        chk({t, "_clr_ff"},   cur_ff, 0);
        chk({t, "_clr_done"}, cur_done, 0);
        chk({t, "_pat0"},     cur_a, 0);
        nbusy = 0;
        cyc   = 0;
        while (!cur_done && cyc < 400) begin
            if (cur_busy) nbusy++;
            set_start(v.sel, (cyc == v.poke) ? 1'b1 : 1'b0);
            cyc++;
            @(negedge clk);
        end
        set_start(v.sel, 1'b0);
        e = sb.pop_front();
        chk({t, "_timeout"}, int'(cyc >= 400), 0);
        chk({t, "_busy_cycles"}, nbusy, e.exp_busy);
        chk({t, "_errcnt"}, cur_err, e.exp_err);
        chk({t, "_first_fail"}, cur_ff, e.exp_ff);
        chk({t, "_pass"}, cur_pass, e.exp_pass);
        chk({t, "_busy_done"}, cur_busy, 0);
        chk({t, "_a_hold"}, cur_a, 15);
    endtask

    initial begin
        int cyc;
        int gap;

        vecs[0] = '{0, 0, -1,  0, 4'h0, 1'b1, 32};
        vecs[1] = '{0, 1, -1,  1, 4'hF, 1'b0, 32};
        vecs[2] = '{0, 2, -1, 15, 4'h0, 1'b0, 32};
        vecs[3] = '{1, 3, -1, 14, 4'h1, 1'b0, 16};
        vecs[4] = '{0, 4, -1,  7, 4'h1, 1'b0, 32};
        vecs[5] = '{1, 5, -1, 16, 4'h0, 1'b0, 16};
        vecs[6] = '{0, 0,  5,  0, 4'h0, 1'b1, 32};
        vecs[7] = '{1, 0, -1,  0, 4'h0, 1'b1, 16};

        rn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rn = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // Reset in the middle of a sweep that has already logged errors.
        sel = 0;
        zm2 = 2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (10) @(negedge clk);
        chk("midsweep_busy", busy2, 1);
        rn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // START held high on the SETTLE=1 instance: DONE shows for one cycle between sweeps.
        sel = 1;
        zm1 = 0;
        start1 = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!done1 && cyc < 100) begin cyc++; @(negedge clk); end
        chk("hold_first_done", int'(cyc < 100), 1);
        chk("hold_pass", pass1, 1);
        @(negedge clk);
        chk("hold_done_one_cycle", done1, 0);
        chk("hold_restart_busy", busy1, 1);
        gap = 1;
        while (!done1 && gap < 100) begin gap++; @(negedge clk); end
        chk("hold_period", gap, 17);
        start1 = 1'b0;
        @(negedge clk);
        chk("hold_release_done", done1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
